// File: rtl/multi_dataflow_package.sv
// multi_dataflow_package: shared types and constants for the multi_dataflow round-constant path
package multi_dataflow_package;
  localparam logic [7:0] AES_POLY_REDUCE = 8'h1B;
  localparam int RC_MAX_ROUNDS = 14;
  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, DONE = 2'd2} rc_gen_state_t;
  typedef struct packed {
    logic [3:0]  n_rounds;
    logic [15:0] n_blocks;
    logic [7:0]  rc_init;
  } ctrl_rc_gen_t;
endpackage

// File: rtl/multi_dataflow_rc_xtime.sv
// multi_dataflow_rc_xtime: combinational GF(2^8) multiply-by-2 (AES xtime)
module multi_dataflow_rc_xtime
  import multi_dataflow_package::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  assign y_o = {a_i[6:0], 1'b0} ^ (a_i[7] ? AES_POLY_REDUCE : 8'h00);
endmodule

// File: rtl/multi_dataflow_rc_gen.sv
// multi_dataflow_rc_gen: on-chip AES round-constant stream source, restarted per block
module multi_dataflow_rc_gen
  import multi_dataflow_package::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_ROUNDS = RC_MAX_ROUNDS,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [3:0]              n_rounds_i,
  input  logic [CNT_WIDTH-1:0]    n_blocks_i,
  input  logic [7:0]              rc_init_i,
  output logic                    rc_valid_o,
  input  logic                    rc_ready_i,
  output logic [DATA_WIDTH-1:0]   rc_data_o,
  output logic [DATA_WIDTH/8-1:0] rc_strb_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CNT_WIDTH-1:0]    blk_cnt_o
);
  rc_gen_state_t state_q, state_d;
  logic [3:0] nr_q, nr_d, round_q, round_d, nr_sat;
  logic [CNT_WIDTH-1:0] nb_q, nb_d, blk_q, blk_d;
  logic [7:0] init_q, init_d, byte_q, byte_d, byte_x;
  logic xfer, last_round, last_blk;
  multi_dataflow_rc_xtime u_xtime (.a_i(byte_q), .y_o(byte_x));
  assign nr_sat = n_rounds_i > 4'(MAX_ROUNDS) ? 4'(MAX_ROUNDS) : n_rounds_i;
  assign xfer = (state_q == EMIT) && rc_ready_i;
  assign last_round = round_q == nr_q - 4'd1;
  assign last_blk = blk_q + 1'b1 == nb_q;
  always_comb begin
    state_d = state_q;
    nr_d = nr_q;
    nb_d = nb_q;
    init_d = init_q;
    byte_d = byte_q;
    round_d = round_q;
    blk_d = blk_q;
    if (state_q == IDLE && start_i) begin
      nr_d = nr_sat;
      nb_d = n_blocks_i;
      init_d = rc_init_i;
      byte_d = rc_init_i;
      round_d = '0;
      blk_d = '0;
      state_d = (nr_sat == '0 || n_blocks_i == '0) ? DONE : EMIT;
    end else if (xfer) begin
      round_d = last_round ? '0 : round_q + 4'd1;
      byte_d = last_round ? init_q : byte_x;
      blk_d = last_round ? blk_q + 1'b1 : blk_q;
      state_d = (last_round && last_blk) ? DONE : EMIT;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= IDLE;
      nr_q <= '0;
      nb_q <= '0;
      init_q <= '0;
      byte_q <= '0;
      round_q <= '0;
      blk_q <= '0;
    end else begin
      state_q <= state_d;
      nr_q <= nr_d;
      nb_q <= nb_d;
      init_q <= init_d;
      byte_q <= byte_d;
      round_q <= round_d;
      blk_q <= blk_d;
    end
  end
  assign rc_valid_o = state_q == EMIT;
  assign busy_o = rc_valid_o;
  assign done_o = state_q == DONE;
  assign blk_cnt_o = blk_q;
  assign rc_data_o = rc_valid_o ? DATA_WIDTH'(byte_q) << (DATA_WIDTH - 8) : '0;
  assign rc_strb_o = {(DATA_WIDTH/8){rc_valid_o}};
endmodule

// File: tb/tb_multi_dataflow_rc_gen.sv
// tb_multi_dataflow_rc_gen: table-driven and randomized checks against a byte-sequence model
module tb_multi_dataflow_rc_gen;
  logic clk = 1'b0;
  logic rst, clear, start, ready, valid, busy, done;
  logic [3:0] n_rounds;
  logic [15:0] n_blocks, blk_cnt;
  logic [7:0] rc_init;
  logic [31:0] data;
  logic [3:0] strb;
  int checks = 0;
  int failures = 0;
  logic [7:0] obs[$];
  logic [7:0] ref_obs[$];
  always #5 clk = ~clk;
  multi_dataflow_rc_gen dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
    .n_rounds_i(n_rounds), .n_blocks_i(n_blocks), .rc_init_i(rc_init),
    .rc_valid_o(valid), .rc_ready_i(ready), .rc_data_o(data), .rc_strb_o(strb),
    .busy_o(busy), .done_o(done), .blk_cnt_o(blk_cnt)
  );
  typedef struct {
    int nr;
    int nb;
    logic [7:0] init;
    int pct;
    int exp_beats;
    int exp_blk;
  } vec_t;
  vec_t vecs[$];
  function automatic logic [7:0] gf_double(input logic [7:0] b);
    int v;
    v = int'(b) * 2;
    if (v >= 256) v = (v - 256) ^ 27;
    return v[7:0];
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 64'(valid), 0);
    chk({tag, "_data"}, 64'(data), 0);
    chk({tag, "_strb"}, 64'(strb), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_blk"}, 64'(blk_cnt), 0);
  endtask
  task automatic run_job(input int nr, input int nb, input logic [7:0] init, input int pct, input int inject_at);
    logic [7:0] q[$];
    logic [7:0] r;
    logic [31:0] prev;
    int enr, done_cnt, done_cyc, last_hs, first_v, hs, cyc;
    bit stall, injected;
    enr = nr > 14 ? 14 : nr;
    for (int b = 0; b < nb; b++) begin
      r = init;
      for (int k = 0; k < enr; k++) begin
        q.push_back(r);
        r = gf_double(r);
      end
    end
    obs.delete();
    @(negedge clk);
    n_rounds = nr[3:0];
    n_blocks = nb[15:0];
    rc_init = init;
    start = 1'b1;
    ready = 1'b0;
    done_cnt = 0; done_cyc = -100; last_hs = -1; first_v = -1; hs = 0;
    stall = 0; injected = 0; prev = '0;
    for (cyc = 1; cyc < 2000 && !(done_cnt > 0 && cyc > done_cyc + 2); cyc++) begin
      @(negedge clk);
      start = 1'b0;
      chk("busy_eq_valid", 64'(busy), 64'(valid));
      if (stall) begin
        chk("stall_hold_valid", 64'(valid), 1);
        chk("stall_hold_data", 64'(data), 64'(prev));
      end
      if (valid) begin
        if (first_v < 0) begin
          first_v = cyc;
          chk("first_beat_latency", 64'(cyc), 1);
          chk("blk_cnt_cleared", 64'(blk_cnt), 0);
        end
        chk("beat_expected", 64'(q.size() > 0), 1);
        if (q.size() > 0) chk("beat_data", 64'(data), 64'({q[0], 24'h0}));
        chk("beat_strb", 64'(strb), 64'hF);
      end else begin
        chk("idle_data", 64'(data), 0);
        chk("idle_strb", 64'(strb), 0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      ready = ($urandom_range(99) < pct);
      if (valid && ready) begin
        obs.push_back(data[31:24]);
        if (q.size() > 0) void'(q.pop_front());
        hs++;
        last_hs = cyc;
      end
      stall = valid && !ready;
      prev = data;
      if (inject_at >= 0 && hs == inject_at && !injected) begin
        injected = 1;
        start = 1'b1;
        n_rounds = 4'd2;
        n_blocks = 16'd1;
        rc_init = 8'h55;
      end
    end
    ready = 1'b0;
    start = 1'b0;
    chk("done_once", 64'(done_cnt), 1);
    chk("beats_left", 64'(q.size()), 0);
    chk("final_blk_cnt", 64'(blk_cnt), 64'(enr == 0 ? 0 : nb));
    if (last_hs >= 0) chk("done_after_last_beat", 64'(done_cyc - last_hs), 1);
    else chk("degenerate_done_timing", 64'(done_cyc >= 1 && done_cyc <= 2), 1);
  endtask
  initial begin
    logic [7:0] basic[10];
    logic [7:0] pat4[4];
    int hs;
    basic = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    pat4 = '{8'h01, 8'h02, 8'h04, 8'h08};
    vecs = '{
      '{10, 1, 8'h01, 100, 10, 1},
      '{4, 3, 8'h01, 100, 12, 3},
      '{10, 2, 8'h01, 50, 20, 2},
      '{15, 1, 8'h01, 100, 14, 1},
      '{0, 3, 8'h01, 100, 0, 0},
      '{5, 0, 8'h01, 100, 0, 0},
      '{3, 4, 8'h8D, 70, 12, 4},
      '{1, 5, 8'h80, 60, 5, 5},
      '{14, 1, 8'h01, 100, 14, 1}
    };
    rst = 1; clear = 0; start = 0; ready = 0;
    n_rounds = 0; n_blocks = 0; rc_init = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 0;
    foreach (vecs[i]) begin
      run_job(vecs[i].nr, vecs[i].nb, vecs[i].init, vecs[i].pct, -1);
      chk("vec_beats", 64'(obs.size()), 64'(vecs[i].exp_beats));
      chk("vec_blk", 64'(blk_cnt), 64'(vecs[i].exp_blk));
    end
    run_job(10, 1, 8'h01, 100, -1);
    chk("basic_len", 64'(obs.size()), 10);
    for (int i = 0; i < 10 && i < obs.size(); i++) chk("basic_seq", 64'(obs[i]), 64'(basic[i]));
    run_job(4, 3, 8'h01, 100, -1);
    chk("multi_len", 64'(obs.size()), 12);
    for (int i = 0; i < 12 && i < obs.size(); i++) chk("multi_seq", 64'(obs[i]), 64'(pat4[i % 4]));
    run_job(15, 1, 8'h01, 100, -1);
    chk("sat_len", 64'(obs.size()), 14);
    if (obs.size() == 14) chk("sat_last", 64'(obs[13]), 64'h4D);
    run_job(10, 2, 8'h01, 100, -1);
    ref_obs = obs;
    run_job(10, 2, 8'h01, 50, -1);
    chk("bp_len", 64'(obs.size()), 64'(ref_obs.size()));
    for (int i = 0; i < obs.size() && i < ref_obs.size(); i++) chk("bp_seq", 64'(obs[i]), 64'(ref_obs[i]));
    run_job(4, 2, 8'h01, 80, 3);
    chk("ignored_start_len", 64'(obs.size()), 8);
    @(negedge clk);
    n_rounds = 4'd10; n_blocks = 16'd1; rc_init = 8'h01; start = 1; ready = 1;
    hs = 0;
    for (int i = 0; i < 50 && hs < 5; i++) begin
      @(negedge clk);
      start = 0;
      if (valid) hs++;
    end
    chk("abort_beats_seen", 64'(hs), 5);
    clear = 1;
    @(negedge clk);
    check_zero("abort");
    clear = 0;
    ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_done", 64'(done), 0);
      chk("abort_no_valid", 64'(valid), 0);
    end
    run_job(10, 1, 8'h01, 100, -1);
    if (obs.size() > 0) chk("restart_first", 64'(obs[0]), 64'h01);
    @(negedge clk);
    n_rounds = 4'd10; n_blocks = 16'd1; rc_init = 8'h01; start = 1; ready = 0;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    chk("stalled_valid", 64'(valid), 1);
    chk("stalled_data", 64'(data), 64'h01000000);
    rst = 1;
    @(negedge clk);
    check_zero("rst_stall");
    rst = 0;
    for (int t = 0; t < 8; t++) begin
      int nr, nb;
      nr = $urandom_range(15);
      nb = $urandom_range(4);
      run_job(nr, nb, 8'($urandom_range(255)), $urandom_range(100, 40), -1);
      chk("rand_beats", 64'(obs.size()), 64'((nr > 14 ? 14 : nr) * nb));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
